// File: rtl/tv80_reg_banked.sv
// tv80_reg_banked: banked register-pair file for the tv80 datapath.
// Three combinational read ports (A/B/C), one write port sharing address A, and an
// EXX-style shadow bank for the pairs selected by SWAP_MASK. A built-in sequencer
// clears every pair of both banks after reset before normal operation begins.
// Optional feature: define TV80_REG_BYPASS_EN to forward write data to matching
// read ports in the same cycle.
module tv80_reg_banked #(
    parameter int unsigned        DW        = 8,
    parameter int unsigned        AW        = 3,
    parameter logic [2**AW-1:0]   SWAP_MASK = 8'b0000_0111
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cen,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] addr_c,
    input  logic [DW-1:0] dih,
    input  logic [DW-1:0] dil,
    input  logic          weh,
    input  logic          wel,
    input  logic          exx,
    output logic [DW-1:0] doah,
    output logic [DW-1:0] doal,
    output logic [DW-1:0] dobh,
    output logic [DW-1:0] dobl,
    output logic [DW-1:0] doch,
    output logic [DW-1:0] docl,
    output logic          bank,
    output logic          init_busy
);

    localparam int unsigned NP = 2**AW;

    typedef enum logic {StClear, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;

    // Storage indexed [physical bank][pair]; not reset, cleared by the sequencer.
    logic [DW-1:0] mem_h_q [2][NP];
    logic [DW-1:0] mem_h_d [2][NP];
    logic [DW-1:0] mem_l_q [2][NP];
    logic [DW-1:0] mem_l_d [2][NP];

    logic          wr_bank;

    // Shared pairs always live in bank 0; banked pairs follow the bank select.
    assign wr_bank   = SWAP_MASK[addr_a] & bank_q;
    assign bank      = bank_q;
    assign init_busy = (state_q == StClear);

    // Sequencer next state: walk the clear counter, then sit in RUN handling EXX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NP - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cen && exx) begin
                    bank_d = ~bank_q;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Sequencer state and bank select, asynchronously reset into CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

    // Storage next state: clear both banks of one pair per cycle, else normal writes.
    // Writes use the bank select from before any same-edge EXX toggle.
    always_comb begin
        mem_h_d = mem_h_q;
        mem_l_d = mem_l_q;
        if (state_q == StClear) begin
            mem_h_d[1'b0][cnt_q] = '0;
            mem_h_d[1'b1][cnt_q] = '0;
            mem_l_d[1'b0][cnt_q] = '0;
            mem_l_d[1'b1][cnt_q] = '0;
        end else if (cen) begin
            if (weh) begin
                mem_h_d[wr_bank][addr_a] = dih;
            end
            if (wel) begin
                mem_l_d[wr_bank][addr_a] = dil;
            end
        end
    end

    // Storage register.
    always_ff @(posedge clk) begin
        mem_h_q <= mem_h_d;
        mem_l_q <= mem_l_d;
    end

    // One read port: {high, low} of pair a, forced to zero while clearing.
    function automatic logic [2*DW-1:0] read_pair(input logic [AW-1:0] a);
        logic          pb;
        logic [DW-1:0] h;
        logic [DW-1:0] l;
        pb = SWAP_MASK[a] & bank_q;
        h  = mem_h_q[pb][a];
        l  = mem_l_q[pb][a];
`ifdef TV80_REG_BYPASS_EN
        if ((state_q == StRun) && cen && (a == addr_a)) begin
            if (weh) begin
                h = dih;
            end
            if (wel) begin
                l = dil;
            end
        end
`endif
        if (state_q != StRun) begin
            h = '0;
            l = '0;
        end
        return {h, l};
    endfunction

    // Combinational read ports.
    always_comb begin
        {doah, doal} = read_pair(addr_a);
        {dobh, dobl} = read_pair(addr_b);
        {doch, docl} = read_pair(addr_c);
    end

endmodule

// File: tb/tb_tv80_reg_banked.sv
// Self-checking bench for tv80_reg_banked (DW=8, AW=3, default SWAP_MASK).
// Honours TV80_REG_BYPASS_EN when defined.
module tb_tv80_reg_banked;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned NP = 8;
    localparam logic [7:0]  MASK = 8'b0000_0111;

    logic          clk;
    logic          reset_n;
    logic          cen;
    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic [DW-1:0] dih, dil;
    logic          weh, wel, exx;
    logic [DW-1:0] doah, doal, dobh, dobl, doch, docl;
    logic          bank;
    logic          init_busy;

    int checks;
    int errors;

    // Reference model: two banks of pairs, bank select, remaining clear cycles.
    logic [7:0] mh [2][8];
    logic [7:0] ml [2][8];
    logic       m_bank;
    int         m_clear_left;

    tv80_reg_banked #(
        .DW       (DW),
        .AW       (AW),
        .SWAP_MASK(MASK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cen      (cen),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .addr_c   (addr_c),
        .dih      (dih),
        .dil      (dil),
        .weh      (weh),
        .wel      (wel),
        .exx      (exx),
        .doah     (doah),
        .doal     (doal),
        .dobh     (dobh),
        .dobl     (dobl),
        .doch     (doch),
        .docl     (docl),
        .bank     (bank),
        .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [7:0] exp_rd(input bit hi, input logic [2:0] a);
        logic       pb;
        logic [7:0] v;
        if (m_clear_left > 0) return 8'h00;
        pb = MASK[a] ? m_bank : 1'b0;
        v  = hi ? mh[pb][a] : ml[pb][a];
`ifdef TV80_REG_BYPASS_EN
        if (cen && (a == addr_a) && (hi ? weh : wel)) v = hi ? dih : dil;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
                mh[b][i] = 8'h00;
                ml[b][i] = 8'h00;
            end
        end
        m_bank       = 1'b0;
        m_clear_left = NP;
    endtask

    // Advance the model by one edge with the current inputs, then cross the edge.
    task automatic tick();
        logic pb;
        if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (cen) begin
            pb = MASK[addr_a] ? m_bank : 1'b0;
            if (weh) mh[pb][addr_a] = dih;
            if (wel) ml[pb][addr_a] = dil;
            if (exx) m_bank = ~m_bank;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cen = 1'b0;
        weh = 1'b0;
        wel = 1'b0;
        exx = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] h, input logic [7:0] l,
                      input logic we_h, input logic we_l, input logic x);
        cen    = 1'b1;
        addr_a = a;
        dih    = h;
        dil    = l;
        weh    = we_h;
        wel    = we_l;
        exx    = x;
        tick();
        idle();
    endtask

    task automatic rd(input logic [2:0] a);
        addr_b = a;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // Walk CLEAR with random inputs; everything must read zero, then RUN after NP edges.
    task automatic clear_phase();
        for (int i = 0; i < NP; i++) begin
            cen    = 1'($urandom);
            weh    = 1'($urandom);
            wel    = 1'($urandom);
            exx    = 1'($urandom);
            addr_a = 3'($urandom);
            addr_b = 3'($urandom);
            addr_c = 3'($urandom);
            dih    = 8'($urandom);
            dil    = 8'($urandom);
            #1;
            checks++;
            if (init_busy !== 1'b1) begin
                errors++;
                $display("FAIL clear_busy[%0d]: got %b required 1", i, init_busy);
            end
            checks++;
            if (bank !== 1'b0) begin
                errors++;
                $display("FAIL clear_bank[%0d]: got %b required 0", i, bank);
            end
            checks++;
            if ({doah, doal, dobh, dobl, doch, docl} !== 48'h0) begin
                errors++;
                $display("FAIL clear_outs[%0d]: got %h required 0", i,
                         {doah, doal, dobh, dobl, doch, docl});
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: init_busy got %b required 0", init_busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        addr_a = '0;
        addr_b = '0;
        addr_c = '0;
        dih    = '0;
        dil    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({init_busy, bank} !== 2'b10) begin
            errors++;
            $display("FAIL reset_state: busy/bank got %b required 10", {init_busy, bank});
        end
        checks++;
        if ({doah, doal, dobh, dobl, doch, docl} !== 48'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h required 0", {doah, doal, dobh, dobl, doch, docl});
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        clear_phase();
    endtask

    task automatic test_write_read();
        wr(3'd2, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
        rd(3'd2);
        checks++;
        if ({dobh, dobl} !== 16'h1234) begin
            errors++;
            $display("FAIL write_read: got %h required 1234", {dobh, dobl});
        end
        wr(3'd2, 8'hAB, 8'h00, 1'b1, 1'b0, 1'b0);
        rd(3'd2);
        checks++;
        if ({dobh, dobl} !== 16'hAB34) begin
            errors++;
            $display("FAIL write_high_only: got %h required ab34", {dobh, dobl});
        end
    endtask

    task automatic test_exx();
        wr(3'd0, 8'h11, 8'h11, 1'b1, 1'b1, 1'b0);
        wr(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        rd(3'd0);
        checks++;
        if ({bank, dobh, dobl} !== 17'h1_0000) begin
            errors++;
            $display("FAIL exx_shadow: bank/pair0 got %h required 10000", {bank, dobh, dobl});
        end
        wr(3'd0, 8'h22, 8'h22, 1'b1, 1'b1, 1'b0);
        wr(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        rd(3'd0);
        checks++;
        if ({bank, dobh, dobl} !== 17'h0_1111) begin
            errors++;
            $display("FAIL exx_restore: bank/pair0 got %h required 01111", {bank, dobh, dobl});
        end
        wr(3'd3, 8'h55, 8'h55, 1'b1, 1'b1, 1'b0);
        wr(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        rd(3'd3);
        checks++;
        if ({bank, dobh, dobl} !== 17'h1_5555) begin
            errors++;
            $display("FAIL exx_shared: bank/pair3 got %h required 15555", {bank, dobh, dobl});
        end
        wr(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        rd(3'd3);
        checks++;
        if ({bank, dobh, dobl} !== 17'h0_5555) begin
            errors++;
            $display("FAIL exx_shared_b0: bank/pair3 got %h required 05555", {bank, dobh, dobl});
        end
    endtask

    task automatic test_same_edge();
        wr(3'd1, 8'h77, 8'h77, 1'b1, 1'b1, 1'b1);
        rd(3'd1);
        checks++;
        if ({bank, dobh, dobl} !== 17'h1_0000) begin
            errors++;
            $display("FAIL same_edge: bank/pair1 got %h required 10000", {bank, dobh, dobl});
        end
        wr(3'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        rd(3'd1);
        checks++;
        if ({bank, dobh, dobl} !== 17'h0_7777) begin
            errors++;
            $display("FAIL same_edge_back: bank/pair1 got %h required 07777", {bank, dobh, dobl});
        end
    endtask

    task automatic test_cen_low();
        cen    = 1'b0;
        weh    = 1'b1;
        wel    = 1'b1;
        exx    = 1'b1;
        addr_a = 3'd2;
        dih    = 8'hFF;
        dil    = 8'hFF;
        tick();
        idle();
        rd(3'd2);
        checks++;
        if ({bank, dobh, dobl} !== 17'h0_AB34) begin
            errors++;
            $display("FAIL cen_low: bank/pair2 got %h required 0ab34", {bank, dobh, dobl});
        end
    endtask

    task automatic test_bypass();
        cen    = 1'b1;
        weh    = 1'b1;
        wel    = 1'b1;
        exx    = 1'b0;
        addr_a = 3'd5;
        addr_c = 3'd5;
        dih    = 8'hBE;
        dil    = 8'hEF;
        #1;
        checks++;
`ifdef TV80_REG_BYPASS_EN
        if ({doch, docl} !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h required beef", {doch, docl});
        end
`else
        if ({doch, docl} !== 16'h0000) begin
            errors++;
            $display("FAIL no_bypass_same_cycle: got %h required 0000", {doch, docl});
        end
`endif
        tick();
        idle();
        #1;
        checks++;
        if ({doch, docl} !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h required beef", {doch, docl});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cen    = ($urandom_range(0, 3) != 0);
            weh    = 1'($urandom);
            wel    = 1'($urandom);
            exx    = ($urandom_range(0, 7) == 0);
            addr_a = 3'($urandom);
            addr_b = 3'($urandom);
            addr_c = 3'($urandom);
            dih    = 8'($urandom);
            dil    = 8'($urandom);
            #1;
            checks++;
            if ({doah, doal} !== {exp_rd(1'b1, addr_a), exp_rd(1'b0, addr_a)}) begin
                errors++;
                $display("FAIL rand_port_a[%0d]: got %h required %h", n, {doah, doal},
                         {exp_rd(1'b1, addr_a), exp_rd(1'b0, addr_a)});
            end
            checks++;
            if ({dobh, dobl} !== {exp_rd(1'b1, addr_b), exp_rd(1'b0, addr_b)}) begin
                errors++;
                $display("FAIL rand_port_b[%0d]: got %h required %h", n, {dobh, dobl},
                         {exp_rd(1'b1, addr_b), exp_rd(1'b0, addr_b)});
            end
            checks++;
            if ({doch, docl} !== {exp_rd(1'b1, addr_c), exp_rd(1'b0, addr_c)}) begin
                errors++;
                $display("FAIL rand_port_c[%0d]: got %h required %h", n, {doch, docl},
                         {exp_rd(1'b1, addr_c), exp_rd(1'b0, addr_c)});
            end
            checks++;
            if ({init_busy, bank} !== {1'b0, m_bank}) begin
                errors++;
                $display("FAIL rand_state[%0d]: busy/bank got %b required %b", n,
                         {init_busy, bank}, {1'b0, m_bank});
            end
            tick();
        end
        idle();
    endtask

    task automatic test_clear_garbage();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NP; i++) begin
                wr(3'(i), 8'hA0 | 8'(i), 8'h5A, 1'b1, 1'b1, 1'b0);
            end
            wr(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        do_reset();
        clear_phase();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NP; i++) begin
                rd(3'(i));
                checks++;
                if ({dobh, dobl} !== 16'h0000) begin
                    errors++;
                    $display("FAIL garbage_cleared[b%0d p%0d]: got %h required 0000", b, i,
                             {dobh, dobl});
                end
            end
            wr(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({init_busy, bank} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset: busy/bank got %b required 10", {init_busy, bank});
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        clear_phase();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_exx();
        test_same_edge();
        test_cen_low();
        test_bypass();
        test_random();
        test_clear_garbage();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tv80_reg_banked.md
Name: tv80_reg_banked

Overview:
Parametrised successor to the TV80 register file: a banked register-pair store with three combinational read ports and one write port. Supports a shadow bank for EXX-style swapping of selected pairs. Clears all storage after reset with a built-in sequencer. Sits between the tv80 core datapath and its register addressing logic, replacing the flat pair array.

Parameters:
DW, 8, width of each register half (H and L)
AW, 3, pair address width; pair count NP = 2**AW
SWAP_MASK, 8'b0000_0111, NP-bit mask; bit i set = pair i is banked (shadowed), clear = pair i is shared

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cen  in  1  clock enable for writes and bank swap
addr_a  in  AW  write address and read port A address
addr_b  in  AW  read port B address
addr_c  in  AW  read port C address
dih  in  DW  write data, high half
dil  in  DW  write data, low half
weh  in  1  write enable, high half
wel  in  1  write enable, low half
exx  in  1  swap request: toggles bank select for banked pairs
doah, doal  out  DW each  port A read data, high/low
dobh, dobl  out  DW each  port B read data
doch, docl  out  DW each  port C read data
bank  out  1  current bank select
init_busy  out  1  clear sequencer active

Behaviour:
- Storage: 2 banks x NP pairs x {H,L}, DW bits each. Physical bank for pair i = SWAP_MASK[i] ? bank : 0.
- Reset (reset_n low, async): bank=0, state=CLEAR, clear counter=0, init_busy=1. Storage is not reset asynchronously.
- FSM states: CLEAR, RUN.
  - CLEAR: each clk, independent of cen, write 0 to H and L of pair[counter] in both banks. Counter increments.
  - CLEAR: when counter == NP-1, the final entry is cleared and the next state is RUN. CLEAR lasts exactly NP cycles after reset release.
  - RUN: init_busy=0; normal operation; no exit except reset.
- Reset asserted mid-CLEAR restarts the counter at 0. Reset in RUN re-enters CLEAR.
- During CLEAR:
  - all read outputs are forced to 0;
  - weh, wel and exx are ignored;
  - bank stays 0.
- Writes in RUN, on a cen=1 edge:
  - weh=1 writes dih to H of the physical pair addressed by addr_a;
  - wel=1 writes dil to L of the same pair;
  - the halves are independent.
- exx in RUN, on a cen=1 edge: bank <= ~bank.
  - A write in the same cycle targets the bank selected before the toggle.
  - Reads in the same cycle also use the old bank.
- cen=0: no writes, no bank toggle. Reads remain live.
- Reads (RUN): purely combinational from current storage and bank. Read-after-write latency is 1 cycle: new data is visible after the write edge.
- Shared pairs (mask bit 0) always use bank 0 storage. The bank-1 copy is unused but still cleared.
- Address values outside 0..NP-1 cannot occur (AW exact).

Optional Feature:
Macro TV80_REG_BYPASS_EN.
- Defined, in RUN: when cen=1 and weh=1 and a read port address equals addr_a, that port's H output returns dih in the same cycle. The same rule applies to wel/L with dil. The bypass uses the pre-toggle bank and does not apply during CLEAR.
- Undefined: no bypass; reads show stored data only, and written data appears the cycle after the write.

Test Plan:
- Reset, then release with AW=3: init_busy=1 for exactly 8 cycles then 0. All six outputs read 0x00 throughout. After CLEAR, reading every pair returns 0x0000, including pre-reset garbage.
- RUN, write addr_a=2 dih=0x12 dil=0x34 weh=wel=1, then read addr_b=2 -> dobh=0x12, dobl=0x34 next cycle. A weh-only write of 0xAB -> 0xAB34.
- Write pair0=0x1111 (bank 0), pulse exx -> bank=1 and pair0 reads 0x0000. Write 0x2222, pulse exx -> pair0 reads 0x1111. Pair3 (shared) written 0x5555 reads 0x5555 in both banks.
- Same edge: exx=1 plus write pair1=0x7777 with bank=0 -> bank=1, pair1 reads 0x0000. After another exx, pair1 reads 0x7777.
- cen=0 with weh=wel=exx=1 and data 0xFFFF -> storage and bank unchanged.
- Reset asserted at CLEAR cycle 4 and released -> init_busy stays high for 8 full cycles from release. With TV80_REG_BYPASS_EN, a RUN write of 0xBEEF to addr_a=5 with addr_c=5 shows doch/docl=0xBEEF in the same cycle.
